// File: rtl/clkdiv_pkg.sv
// Shared defaults and board divisor constants for the multi-channel clock/tick divider.
// Channel-index width helper keeps a 1-channel build at a legal 1-bit index.
package clkdiv_pkg;

  localparam int W_DEF   = 28;
  localparam int NCH_DEF = 3;

  // Board-level divisors at 100 MHz (terminal count values)
  localparam logic [W_DEF-1:0] DIV_50M  = 28'd50_000_000;
  localparam logic [W_DEF-1:0] DIV_80M  = 28'd80_000_000;
  localparam logic [W_DEF-1:0] DIV_110M = 28'd110_000_000;

  function automatic int chw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/div_channel.sv
// One divider channel: up-counter to a glitch-free programmable terminal count,
// 1-cycle tick, square-wave output and a shadowed divisor register.
module div_channel
  import clkdiv_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         sync,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic [W-1:0] def_div,
  output logic         pend,
  output logic         tick,
  output logic         clk_div
);

  logic [W-1:0] r_cnt;
  logic [W-1:0] r_active;
  logic [W-1:0] r_shadow;
  logic         w_term;

  // >= rather than == so a counter left above a divisor shrunk while disabled
  // terminates on its next enabled cycle instead of wrapping.
  assign w_term = (r_cnt >= r_active);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_active <= def_div;
      r_shadow <= def_div;
      pend     <= 1'b0;
      tick     <= 1'b0;
      clk_div  <= 1'b0;
    end else if (sync) begin
      r_cnt   <= '0;
      clk_div <= 1'b0;
      tick    <= 1'b0;
      pend    <= 1'b0;
      if (ld) begin
        r_active <= ld_val;
        r_shadow <= ld_val;
      end else if (pend) begin
        r_active <= r_shadow;
      end
    end else if (!en) begin
      tick <= 1'b0;
      if (pend) begin
        r_active <= r_shadow;
        pend     <= 1'b0;
      end
      if (ld) begin
        r_shadow <= ld_val;
        pend     <= 1'b1;
      end
    end else if (w_term) begin
      tick    <= 1'b1;
      clk_div <= ~clk_div;
      r_cnt   <= '0;
      if (ld) begin
        r_active <= ld_val;
        r_shadow <= ld_val;
        pend     <= 1'b0;
      end else if (pend) begin
        r_active <= r_shadow;
        pend     <= 1'b0;
      end
    end else begin
      r_cnt <= r_cnt + W'(1);
      tick  <= 1'b0;
      if (ld) begin
        r_shadow <= ld_val;
        pend     <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_clk_divider.sv
// N-channel clock/tick divider: decodes divisor writes into per-channel load
// strobes and packs the per-channel outputs onto flat buses.
module multi_clk_divider
  import clkdiv_pkg::*;
#(
  parameter int               NCH     = NCH_DEF,
  parameter int               W       = W_DEF,
  parameter logic [NCH*W-1:0] DEF_DIV = {NCH{DIV_50M}}
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       en,
  input  logic                 sync,
  input  logic                 wr_en,
  input  logic [chw(NCH)-1:0]  wr_ch,
  input  logic [W-1:0]         wr_div,
  output logic [NCH-1:0]       pend,
  output logic [NCH-1:0]       tick,
  output logic [NCH-1:0]       clk_div
);

  localparam int CHW = chw(NCH);

  logic [NCH-1:0] w_ld;

  // Out-of-range channel indices match no channel, so such writes vanish.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    assign w_ld[gi] = wr_en && (wr_ch == CHW'(gi));

    div_channel #(
      .W (W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (en[gi]),
      .sync    (sync),
      .ld      (w_ld[gi]),
      .ld_val  (wr_div),
      .def_div (DEF_DIV[gi*W +: W]),
      .pend    (pend[gi]),
      .tick    (tick[gi]),
      .clk_div (clk_div[gi])
    );
  end

endmodule
